// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, port ids,
// captured request and response-tag layouts.
package mem_arb_pkg;

    // Geometry of the MemGen_16_10 macro; mem_req_t is sized to it.
    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic vld;
        logic port;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the port that wins a tie and
// moves to the losing side after every grant taken while advance is high.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_ptr;

    always_comb begin
        gnt = req;
        if (&req)
            gnt = (r_ptr == PORT_A) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            r_ptr <= PORT_A;
        else if (advance && (|gnt))
            r_ptr <= gnt[PORT_A] ? PORT_B : PORT_A;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates ports A and B onto one single-port SRAM macro: zero-fills the
// array after reset, then issues one access per cycle and routes read data back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int RD_LAT     = 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic              mem_chip_en,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              init_done
);

    localparam state_e ST_RESET = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_run;
    logic [1:0]        w_valid;
    logic [1:0]        w_gnt;
    logic [1:0]        w_ready;
    logic [1:0]        w_accept;
    logic              w_any_acc;
    mem_req_t          w_req;

    logic              r_chip_en;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_init_done;

    // Tag slot 0 lines up with the macro strobe; slot RD_LAT with mem_rd_data.
    rsp_tag_t [RD_LAT:0] r_tag_pipe;
    rsp_tag_t            w_rsp_tag;

    assign w_run   = (r_state == ST_RUN);
    assign w_valid = {b_req_valid, a_req_valid};

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .rst_n   (rst_n),
        .req     (w_valid),
        .advance (w_run),
        .gnt     (w_gnt)
    );

    always_ff @(posedge clock) begin
        if (!rst_n)
            r_state <= ST_RESET;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == '1)
            w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_ready = 2'b00;
        if (r_state == ST_RUN)
            w_ready = w_gnt;
    end

    assign a_req_ready = w_ready[PORT_A];
    assign b_req_ready = w_ready[PORT_B];
    assign w_accept    = w_valid & w_ready;
    assign w_any_acc   = |w_accept;

    always_comb begin
        if (w_accept[PORT_B])
            w_req = '{we: b_req_we, addr: b_req_addr, wdata: b_req_wdata};
        else
            w_req = '{we: a_req_we, addr: a_req_addr, wdata: a_req_wdata};
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == ST_INIT)
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_chip_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else if (r_state == ST_INIT) begin
            r_chip_en <= 1'b1;
            r_wr_en   <= 1'b1;
            r_rd_en   <= 1'b0;
            r_addr    <= r_cnt;
            r_wr_data <= '0;
        end else begin
            r_chip_en <= w_any_acc;
            r_wr_en   <= w_any_acc & w_req.we;
            r_rd_en   <= w_any_acc & ~w_req.we;
            r_addr    <= w_req.addr;
            r_wr_data <= w_req.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_tag_pipe <= '0;
        end else begin
            r_tag_pipe[0] <= rsp_tag_t'{vld: w_any_acc & ~w_req.we, port: w_accept[PORT_B]};
            for (int i = 1; i <= RD_LAT; i++)
                r_tag_pipe[i] <= r_tag_pipe[i-1];
        end
    end

    // Lags the FSM by one cycle so it rises after the final clear write is on the pins.
    always_ff @(posedge clock) begin
        if (!rst_n)
            r_init_done <= 1'b0;
        else
            r_init_done <= (r_state == ST_RUN);
    end

    assign w_rsp_tag   = r_tag_pipe[RD_LAT];
    assign a_rsp_valid = w_rsp_tag.vld & (w_rsp_tag.port == PORT_A);
    assign b_rsp_valid = w_rsp_tag.vld & (w_rsp_tag.port == PORT_B);
    assign a_rsp_rdata = mem_rd_data;
    assign b_rsp_rdata = mem_rd_data;

    assign mem_chip_en = r_chip_en;
    assign mem_wr_en   = r_wr_en;
    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wr_data;
    assign init_done   = r_init_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM, a reference
// memory and a response scoreboard checked on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int RL = 1;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic [DW-1:0] a_req_wdata = '0;
    logic          b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [AW-1:0] b_req_addr = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
    logic          mem_chip_en, mem_wr_en, mem_rd_en, init_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .INIT_CLEAR(1'b1)) dut (
        .clock(clock), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .mem_chip_en(mem_chip_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    // Behavioural macro, one cycle read latency; powers up with junk.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_chip_en) begin
            if (mem_wr_en)
                sram[mem_addr] <= mem_wr_data;
            else if (mem_rd_en)
                mem_rd_data <= sram[mem_addr];
        end
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic          exp_mv = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic capture(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
        exp_t e;
        exp_mv   = 1'b1;
        exp_we   = we;
        exp_addr = addr;
        exp_wd   = wd;
        if (we) begin
            ref_mem[addr] = wd;
        end else begin
            e.port = port;
            e.data = ref_mem[addr];
            e.cyc  = cyc + 1 + RL;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard and macro-pin monitor.
    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            check("rsp_vld", {30'd0, b_rsp_valid, a_rsp_valid}, mon_e.port ? 32'd2 : 32'd1);
            check("rsp_data", mon_e.port ? b_rsp_rdata : a_rsp_rdata, mon_e.data);
        end else if (a_rsp_valid || b_rsp_valid) begin
            check("rsp_unexpected", {30'd0, b_rsp_valid, a_rsp_valid}, 32'd0);
        end
        if (init_done === 1'b1) begin
            check("mem_en", {29'd0, mem_chip_en, mem_wr_en, mem_rd_en},
                  exp_mv ? {29'd0, 1'b1, exp_we, ~exp_we} : 32'd0);
            if (exp_mv) begin
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", mem_wr_data, exp_wd);
            end
        end
        exp_mv = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else if (a_req_valid && a_req_ready) begin
            capture(1'b0, a_req_we, a_req_addr, a_req_wdata);
        end else if (b_req_valid && b_req_ready) begin
            capture(1'b1, b_req_we, b_req_addr, b_req_wdata);
        end
    end

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd;
    endtask

    // Check readiness for the cycle just driven, then land at posedge+1.
    task automatic step(input logic ea, input logic eb, input string tag);
        @(negedge clock);
        check({tag, "_a_rdy"}, a_req_ready, ea);
        check({tag, "_b_rdy"}, b_req_ready, eb);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(posedge clock); #1;
        check("rst_mem_en", {29'd0, mem_chip_en, mem_wr_en, mem_rd_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wr_data, 32'd0);
        check("rst_init_done", init_done, 32'd0);
        rst_n = 1'b1;
    endtask

    // Both ports hold a read during the clear so ready can be seen held low.
    task automatic run_init(input logic [AW-1:0] a_ad, input logic [AW-1:0] b_ad);
        int n = 0, bad = 0, rdy_bad = 0, last_k = -10, done_k = -1;
        set_a(1'b1, 1'b0, a_ad, '0);
        set_b(1'b1, 1'b0, b_ad, '0);
        for (int k = 0; k < 1100 && done_k < 0; k++) begin
            @(negedge clock);
            if (init_done) begin
                done_k = k;
            end else if (mem_wr_en) begin
                if (mem_addr !== AW'(n) || mem_wr_data !== '0 || mem_chip_en !== 1'b1 || mem_rd_en !== 1'b0)
                    bad++;
                if (mem_addr != '1 && (a_req_ready || b_req_ready))
                    rdy_bad++;
                n++;
                last_k = k;
            end
        end
        check("init_done_seen", (done_k >= 0), 32'd1);
        check("init_writes", n, 32'd1024);
        check("init_seq", bad, 32'd0);
        check("init_ready", rdy_bad, 32'd0);
        check("init_done_lag", done_k - last_k, 32'd1);
        @(posedge clock); #1;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ai, bi;
        logic ea;
        foreach (sram[i]) sram[i] = 16'hDEAD;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        do_reset();
        run_init(10'd10, 10'd20);

        // A writes then reads the top word.
        set_a(1'b1, 1'b1, 10'h3FF, 16'hBEEF); step(1'b1, 1'b0, "a_wr");
        set_a(1'b1, 1'b0, 10'h3FF, 16'h0000); step(1'b1, 1'b0, "a_rd");
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b1, 1'b1, 10'd101, 16'h2222); step(1'b0, 1'b1, "b_wr101");
        set_b(1'b0, 1'b0, '0, '0);
        set_a(1'b1, 1'b1, 10'd1, 16'h1111);   step(1'b1, 1'b0, "a_wr1");
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b1, 1'b1, 10'd2, 16'h3333);   step(1'b0, 1'b1, "b_wr2");
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b0, 1'b0, "idle");

        // Contention with pointer at A: strict alternation.
        ai = 0; bi = 0;
        for (int k = 0; k < 6; k++) begin
            set_a(1'b1, 1'b0, AW'(ai), '0);
            set_b(1'b1, 1'b0, AW'(100 + bi), '0);
            ea = (k % 2 == 0);
            step(ea, ~ea, "rr");
            if (ea) ai++; else bi++;
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b0, 1'b0, "idle");

        // Same-cycle write/read of one address: A first, B sees new data.
        set_a(1'b1, 1'b1, 10'd5, 16'h1234);
        set_b(1'b1, 1'b0, 10'd5, 16'h0000);
        step(1'b1, 1'b0, "raw_a");
        set_a(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, "raw_b");
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b0, 1'b0, "idle");

        // B alone for eight back-to-back cycles.
        for (int k = 0; k < 8; k++) begin
            set_b(1'b1, (k < 4), AW'(200 + (k % 4)), DW'(16'hA000 + k));
            step(1'b0, 1'b1, "b_only");
        end
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b0, 1'b0, "idle");

        // Reset right behind an accepted read: the read must vanish.
        set_a(1'b1, 1'b0, 10'h3FF, '0);
        step(1'b1, 1'b0, "pre_rst_rd");
        do_reset();
        run_init(10'h3FF, 10'd101);

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
